// File: rtl/puf_launch_pkg.sv
// Shared types, default sizing and helpers for the arbiter-PUF race launcher.
// Consumers: puf_race_launcher and arb_sync_bank.
package puf_launch_pkg;

  localparam int DEF_N_ARB       = 32;
  localparam int DEF_CHAL_W      = 64;
  localparam int DEF_SETUP_CYC   = 4;
  localparam int DEF_SETTLE_CYC  = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_VOTE_N      = 5;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FIRE,
    SETTLE,
    CAPTURE,
    RESP
  } launch_state_e;

  // Per-lane vote counter must hold values 0..vote_n inclusive.
  function automatic int vote_cnt_w(input int vote_n);
    return (vote_n < 1) ? 1 : $clog2(vote_n + 1);
  endfunction

endpackage

// File: rtl/arb_sync_bank.sv
// Per-lane multi-flop synchronizer bringing the asynchronous arbiter outputs into clk.
// Flops are attributed so synthesis keeps every stage distinct and unmerged.
module arb_sync_bank
  import puf_launch_pkg::*;
#(
  parameter int N_ARB       = DEF_N_ARB,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_ARB-1:0] i_arb_q,
  output logic [N_ARB-1:0] o_arb_sync
);

  (* keep = "true", dont_touch = "true", async_reg = "true" *)
  logic [N_ARB-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= i_arb_q;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign o_arb_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/puf_race_launcher.sv
// Arbiter-PUF launch controller: accepts a challenge, fires the race, returns a response word.
// Optional majority voting over VOTE_N evaluations is enabled with `define PUF_MAJORITY_VOTE_EN.
module puf_race_launcher
  import puf_launch_pkg::*;
#(
  parameter int N_ARB       = DEF_N_ARB,
  parameter int CHAL_W      = DEF_CHAL_W,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int VOTE_N      = DEF_VOTE_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chal_valid,
  output logic              chal_ready,
  input  logic [CHAL_W-1:0] chal_data,
  output logic [CHAL_W-1:0] pdl_ctrl,
  output logic [N_ARB-1:0]  race_launch,
  input  logic [N_ARB-1:0]  arb_q,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N_ARB-1:0]  resp_data,
  output logic              busy
);

  localparam int SETTLE_TOT = SETTLE_CYC + SYNC_STAGES;
  localparam int CNT_MAX    = (SETUP_CYC > SETTLE_TOT) ? SETUP_CYC : SETTLE_TOT;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int VOTE_W     = vote_cnt_w(VOTE_N);
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int EVAL_LAST  = VOTE_N - 1;
`else
  localparam int EVAL_LAST  = 0;
`endif

  launch_state_e     r_state;
  launch_state_e     w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [VOTE_W-1:0] r_eval;
  logic [CHAL_W-1:0] r_pdl;
  logic [N_ARB-1:0]  r_launch;
  logic [N_ARB-1:0]  r_resp;
  logic              r_armed;
  logic [N_ARB-1:0]  w_sync;
  logic [N_ARB-1:0]  w_result;
  logic              w_accept;
  logic              w_last_eval;
  logic              w_phase_done;

  arb_sync_bank #(
    .N_ARB       (N_ARB),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_arb_q    (arb_q),
    .o_arb_sync (w_sync)
  );

  // r_armed keeps chal_ready low until the first clock after reset release.
  assign chal_ready  = (r_state == IDLE) && r_armed;
  assign w_accept    = chal_valid && chal_ready;
  assign w_last_eval = (r_eval == VOTE_W'(EVAL_LAST));

  always_comb begin
    w_phase_done = 1'b0;
    case (r_state)
      CLEAR:   w_phase_done = (r_cnt == CNT_W'(SETUP_CYC - 1));
      SETTLE:  w_phase_done = (r_cnt == CNT_W'(SETTLE_TOT - 1));
      default: w_phase_done = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CLEAR;
      CLEAR:   if (w_phase_done) w_next = FIRE;
      FIRE:    w_next = SETTLE;
      SETTLE:  if (w_phase_done) w_next = CAPTURE;
      CAPTURE: w_next = w_last_eval ? RESP : CLEAR;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

`ifdef PUF_MAJORITY_VOTE_EN
  logic [VOTE_W-1:0] r_vote      [N_ARB];
  logic [VOTE_W-1:0] w_vote_next [N_ARB];

  always_comb begin
    w_result = '0;
    for (int i = 0; i < N_ARB; i++) begin
      w_vote_next[i] = r_vote[i] + VOTE_W'(w_sync[i]);
      w_result[i]    = (w_vote_next[i] > VOTE_W'(VOTE_N / 2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ARB; i++) r_vote[i] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < N_ARB; i++) r_vote[i] <= '0;
    end else if (r_state == CAPTURE) begin
      for (int i = 0; i < N_ARB; i++) r_vote[i] <= w_vote_next[i];
    end
  end
`else
  assign w_result = w_sync;
`endif

  // Launch rises on the edge leaving FIRE and stays high until CAPTURE, so the
  // PDL taps are always settled before any edge enters the delay lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed  <= 1'b0;
      r_cnt    <= '0;
      r_eval   <= '0;
      r_pdl    <= '0;
      r_launch <= '0;
      r_resp   <= '0;
    end else begin
      r_armed <= 1'b1;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == CLEAR) || (r_state == SETTLE)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_pdl  <= chal_data;
        r_eval <= '0;
      end
      if (r_state == FIRE) begin
        r_launch <= '1;
      end
      if (r_state == CAPTURE) begin
        r_launch <= '0;
        r_eval   <= r_eval + VOTE_W'(1);
        if (w_last_eval) begin
          r_resp <= w_result;
        end
      end
    end
  end

  assign pdl_ctrl    = r_pdl;
  assign race_launch = r_launch;
  assign resp_valid  = (r_state == RESP);
  assign resp_data   = r_resp;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_puf_race_launcher.sv
// Scoreboard bench for puf_race_launcher: directed challenges with hand-computed responses.
// Build with PUF_MAJORITY_VOTE_EN defined to exercise the voting path instead.
module tb_puf_race_launcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chal_valid;
  logic        chal_ready;
  logic [63:0] chal_data;
  logic [63:0] pdl_ctrl;
  logic [31:0] race_launch;
  logic [31:0] arb_q;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  typedef struct {
    logic [31:0] expVal;
    logic [31:0] altVal;
  } exp_t;

  exp_t scoreQ[$];
  exp_t monE;
  int   passCount  = 0;
  int   checkCount = 0;
  int   respCount  = 0;

  puf_race_launcher dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .chal_valid  (chal_valid),
    .chal_ready  (chal_ready),
    .chal_data   (chal_data),
    .pdl_ctrl    (pdl_ctrl),
    .race_launch (race_launch),
    .arb_q       (arb_q),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Monitor: every response handshake pops the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      respCount++;
      checkCount++;
      if (scoreQ.size() == 0) begin
        $display("[TB] FAIL unexpected_resp: got %h, expected no response", resp_data);
      end else begin
        monE = scoreQ.pop_front();
        if (!$isunknown(resp_data) && ((resp_data == monE.expVal) || (resp_data == monE.altVal)))
          passCount++;
        else
          $display("[TB] FAIL resp_data: got %h, expected %h or %h", resp_data, monE.expVal, monE.altVal);
      end
    end
  end

  // Drives a challenge one step after a clock edge; returns just after the accept edge.
  task automatic applyStimulus(input logic [63:0] chal, input logic [31:0] arbVal,
                               input logic [31:0] expVal, input logic [31:0] altVal,
                               input logic rdy, input bit pushExp);
    exp_t e;
    @(posedge clk); #1;
    chal_valid = 1'b1;
    chal_data  = chal;
    arb_q      = arbVal;
    resp_ready = rdy;
    if (pushExp) begin
      e.expVal = expVal;
      e.altVal = altVal;
      scoreQ.push_back(e);
    end
    @(posedge clk); #1;
    chal_valid = 1'b0;
  endtask

  task automatic waitForResp(input string name, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) begin
      checkCount++;
      $display("[TB] FAIL %s_timeout: got no resp_valid, expected one within 300 cycles", name);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int launchAt, respAt, cyc, respBefore;
    logic [31:0] launchVal, launchAtResp;
    rst_n      = 1'b0;
    chal_valid = 1'b0;
    chal_data  = '0;
    arb_q      = '0;
    resp_ready = 1'b1;

    #23;
    checkOutput("rst_chal_ready", 64'(chal_ready), 64'd0);
    checkOutput("rst_pdl_ctrl", pdl_ctrl, 64'd0);
    checkOutput("rst_race_launch", 64'(race_launch), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_resp_data", 64'(resp_data), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("armed_before_clk", 64'(chal_ready), 64'd0);
    @(negedge clk);
    checkOutput("armed_after_clk", 64'(chal_ready), 64'd1);

`ifdef PUF_MAJORITY_VOTE_EN
    begin
      bit v0[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      bit v1[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      int fires = 0;
      int evalIdx = 0;
      logic prevLaunch = 1'b0;
      applyStimulus(64'h1357_9BDF_2468_ACE0, {30'b0, v1[0], v0[0]}, 32'h1, 32'h1, 1'b1, 1'b1);
      for (int i = 0; i < 400 && !resp_valid; i++) begin
        @(negedge clk);
        if (race_launch[0] && !prevLaunch) fires++;
        if (!race_launch[0] && prevLaunch && evalIdx < 4) begin
          evalIdx++;
          arb_q = {30'b0, v1[evalIdx], v0[evalIdx]};
        end
        prevLaunch = race_launch[0];
      end
      checkOutput("vote_fire_count", 64'(fires), 64'd5);
      checkOutput("vote_lane0", 64'(resp_data[0]), 64'd1);
      checkOutput("vote_lane1", 64'(resp_data[1]), 64'd0);
      @(negedge clk);
    end
`else
    // Basic: launch 5 cycles and resp_valid 24 cycles after accept.
    applyStimulus(64'hDEAD_BEEF_0123_4567, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("basic_pdl_ctrl", pdl_ctrl, 64'hDEAD_BEEF_0123_4567);
    checkOutput("basic_busy", 64'(busy), 64'd1);
    checkOutput("basic_chal_ready_low", 64'(chal_ready), 64'd0);
    launchAt = -1;
    respAt = -1;
    launchVal = '0;
    launchAtResp = '1;
    for (int i = 1; i <= 60 && respAt < 0; i++) begin
      @(negedge clk);
      if (race_launch != 0 && launchAt < 0) begin
        launchAt = i;
        launchVal = race_launch;
      end
      if (resp_valid) begin
        respAt = i;
        launchAtResp = race_launch;
      end
    end
    checkOutput("basic_launch_cycle", 64'(launchAt), 64'd5);
    checkOutput("basic_launch_all_ones", 64'(launchVal), 64'hFFFF_FFFF);
    checkOutput("basic_resp_cycle", 64'(respAt), 64'd24);
    checkOutput("basic_launch_dropped", 64'(launchAtResp), 64'd0);

    // Backpressure with a second challenge waiting the whole time.
    applyStimulus(64'h0123_4567_89AB_CDEF, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    chal_valid = 1'b1;
    chal_data  = 64'hFEDC_BA98_7654_3210;
    monE.expVal = 32'hFFFF_0000;
    monE.altVal = 32'hFFFF_0000;
    scoreQ.push_back(monE);
    waitForResp("bp", cyc);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("bp_resp_valid", 64'(resp_valid), 64'd1);
      checkOutput("bp_resp_data", 64'(resp_data), 64'h1234_5678);
      checkOutput("bp_chal_ready", 64'(chal_ready), 64'd0);
      checkOutput("bp_pdl_held", pdl_ctrl, 64'h0123_4567_89AB_CDEF);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bubble_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("bubble_chal_ready", 64'(chal_ready), 64'd1);
    checkOutput("bubble_pdl_not_yet", pdl_ctrl, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    checkOutput("second_accept_pdl", pdl_ctrl, 64'hFEDC_BA98_7654_3210);
    checkOutput("second_accept_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chal_valid = 1'b0;
    arb_q = 32'hFFFF_0000;
    waitForResp("second", cyc);
    @(negedge clk);

    // Busy rejection: a challenge offered during SETTLE is dropped.
    respBefore = respCount;
    applyStimulus(64'hCAFE_F00D_5A5A_C3C3, 32'h0F0F_F0F0, 32'h0F0F_F0F0, 32'h0F0F_F0F0, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chal_valid = 1'b1;
    chal_data  = 64'h1;
    @(posedge clk); #1;
    chal_valid = 1'b0;
    @(negedge clk);
    checkOutput("reject_pdl", pdl_ctrl, 64'hCAFE_F00D_5A5A_C3C3);
    waitForResp("reject", cyc);
    repeat (40) @(negedge clk);
    checkOutput("reject_one_resp", 64'(respCount - respBefore), 64'd1);
    checkOutput("reject_idle", 64'(busy), 64'd0);

    // Reset two cycles after the launch edge.
    applyStimulus(64'h5555_AAAA_5555_AAAA, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (race_launch != 0) begin
        cyc = i;
        break;
      end
    end
    checkOutput("midrace_launch_seen", 64'(cyc >= 0), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrace_launch_async", 64'(race_launch), 64'd0);
    checkOutput("midrace_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrace_chal_ready", 64'(chal_ready), 64'd1);
    checkOutput("midrace_pdl_cleared", pdl_ctrl, 64'd0);
    repeat (30) @(negedge clk);
    checkOutput("midrace_no_resp", 64'(resp_valid), 64'd0);

    // Arbiter outputs change asynchronously near the end of SETTLE.
    applyStimulus(64'h0F1E_2D3C_4B5A_6978, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    #3;
    arb_q = 32'hFFFF_0000;
    waitForResp("meta", cyc);
    checkOutput("meta_no_x", 64'($isunknown(resp_data)), 64'd0);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(scoreQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
